// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Fetches one instruction word at a time from instruction memory, holds it
// (with its decode fields) for the decoder, and advances the PC when the
// datapath consumes it.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   MAX_WAIT  imem wait-cycle limit before fetch_timeout is flagged
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and address (address == PC)
//   imem_ready/imem_rdata memory response
//   instr_valid, Instr    held instruction and its validity
//   op, funct3, funct7b5  decode fields sliced from Instr
//   PC, PCPlus4           address of held instruction and its successor
//   advance, PCSrc,
//   PCTarget              consume / next-PC selection from the datapath
//   misalign_err          sticky: taken target was not word aligned
//   fetch_timeout         sticky: memory did not answer within MAX_WAIT
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        advance,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        misalign_err,
  output logic        fetch_timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             fetch_done;
  logic             consume;
  logic             target_bad;

  assign fetch_done = (state == FETCH) && imem_ready;
  assign consume    = (state == HOLD) && advance;
  assign target_bad = PCSrc && (PCTarget[1:0] != 2'b00);

  assign PCPlus4   = PC + 32'd4;
  assign imem_addr = PC;
  assign op        = Instr[6:0];
  assign funct3    = Instr[14:12];
  assign funct7b5  = Instr[30];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (advance) state_nxt = target_bad ? ERROR : FETCH;
      end
      ERROR: state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC            <= RESET_PC;
      Instr         <= NOP;
      wait_cnt      <= '0;
      misalign_err  <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      if (fetch_done) begin
        Instr    <= imem_rdata;
        wait_cnt <= '0;
      end else if (state == FETCH) begin
        // Counter saturates; flag sets on the edge the count reaches MAX_WAIT.
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= CNT_LAST) fetch_timeout <= 1'b1;
      end

      // A misaligned taken target leaves PC at the faulting instruction.
      if (consume) begin
        if (!PCSrc)          PC           <= PCPlus4;
        else if (!target_bad) PC          <= PCTarget;
        else                  misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- scoreboard bench for fetch_unit.
// Stimulus pushes expected fetch addresses and expected held-instruction
// contents into queues; a negedge monitor pops and compares on every
// memory handshake and every consume.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, instr_valid;
  logic [31:0] imem_addr, imem_rdata, Instr, PC, PCPlus4, PCTarget;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, advance, PCSrc, misalign_err, fetch_timeout;

  logic        w_reset, w_req, w_ready, w_valid, w_advance, w_src;
  logic [31:0] w_addr, w_rdata, w_Instr, w_PC, w_PCPlus4, w_target;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_f7, w_mis, w_to;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  logic [31:0] addr_q[$];
  exp_t        hold_q[$];

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .Instr(Instr), .op(op), .funct3(funct3), .funct7b5(funct7b5), .PC(PC),
    .PCPlus4(PCPlus4), .advance(advance), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .misalign_err(misalign_err), .fetch_timeout(fetch_timeout)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .Instr(w_Instr), .op(w_op), .funct3(w_f3), .funct7b5(w_f7), .PC(w_PC),
    .PCPlus4(w_PCPlus4), .advance(w_advance), .PCSrc(w_src), .PCTarget(w_target),
    .misalign_err(w_mis), .fetch_timeout(w_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: decoupled from stimulus, compares on DUT handshakes.
  always @(negedge clk) begin
    if (imem_req && imem_ready) begin
      if (addr_q.size() == 0) expire("unexpected_fetch");
      else chk("fetch_addr", imem_addr, addr_q.pop_front());
    end
    if (instr_valid && advance) begin
      if (hold_q.size() == 0) expire("unexpected_consume");
      else begin
        exp_t e;
        e = hold_q.pop_front();
        chk("instr",    Instr,    e.instr);
        chk("pc",       PC,       e.pc);
        chk("pcplus4",  PCPlus4,  e.plus4);
        chk("op",       {25'd0, op},     {25'd0, e.op});
        chk("funct3",   {29'd0, funct3}, {29'd0, e.f3});
        chk("funct7b5", {31'd0, funct7b5}, {31'd0, e.f7});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    if (!imem_req) expire("wait_imem_req");
  endtask

  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int delay);
    addr_q.push_back(exp_addr);
    wait_req();
    repeat (delay) tick();
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic consume(input exp_t e, input logic src, input logic [31:0] tgt);
    int n = 0;
    hold_q.push_back(e);
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    if (!instr_valid) expire("wait_instr_valid");
    advance  = 1'b1;
    PCSrc    = src;
    PCTarget = tgt;
    tick();
    advance  = 1'b0;
    PCSrc    = 1'b0;
    PCTarget = 32'h0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req"},      {31'd0, imem_req},      32'd0);
    chk({tag, "_valid"},    {31'd0, instr_valid},   32'd0);
    chk({tag, "_pc"},       PC,                     32'h0);
    chk({tag, "_instr"},    Instr,                  32'h0000_0013);
    chk({tag, "_misalign"}, {31'd0, misalign_err},  32'd0);
    chk({tag, "_timeout"},  {31'd0, fetch_timeout}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    advance = 1'b1; PCSrc = 1'b1; PCTarget = 32'h42;
    w_reset = 1'b1; w_ready = 1'b0; w_rdata = 32'h0; w_advance = 1'b0;
    w_src = 1'b0; w_target = 32'h0;

    // Reset dominates active inputs.
    repeat (3) tick();
    check_reset_state("rst");
    imem_ready = 1'b0; advance = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    imem_rdata = 32'hBAD0_BAD0;
    reset = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // First fetch: addi x1,x0,5 answered immediately.
    fetch(32'h0, 32'h0050_0093, 0);
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_req",   {31'd0, imem_req},    32'd0);
    // Stray ready in HOLD is ignored.
    imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
    repeat (2) tick();
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    consume('{32'h0050_0093, 32'h0, 32'h4, 7'h13, 3'd0, 1'b0}, 1'b0, 32'h0);

    // Sequential fetch with two wait cycles, then a taken branch to 0x40.
    fetch(32'h4, 32'h4020_8133, 2);
    consume('{32'h4020_8133, 32'h4, 32'h8, 7'h33, 3'd0, 1'b1}, 1'b1, 32'h40);

    // Branch target fetch, then misaligned target 0x42.
    fetch(32'h40, 32'h0020_A023, 0);
    consume('{32'h0020_A023, 32'h40, 32'h44, 7'h23, 3'd2, 1'b0}, 1'b1, 32'h42);
    chk("err_misalign", {31'd0, misalign_err}, 32'd1);
    chk("err_pc",       PC,                    32'h40);
    advance = 1'b1; imem_ready = 1'b1;
    repeat (4) tick();
    advance = 1'b0; imem_ready = 1'b0;
    chk("err_req",      {31'd0, imem_req},     32'd0);
    chk("err_valid",    {31'd0, instr_valid},  32'd0);
    chk("err_sticky",   {31'd0, misalign_err}, 32'd1);
    chk("err_pc_hold",  PC,                    32'h40);

    // Reset, then starve the fetch for MAX_WAIT cycles.
    reset = 1'b1;
    repeat (2) tick();
    check_reset_state("rst2");
    reset = 1'b0;
    wait_req();
    repeat (15) tick();
    chk("timeout_early", {31'd0, fetch_timeout}, 32'd0);
    tick();
    chk("timeout_set",   {31'd0, fetch_timeout}, 32'd1);
    chk("timeout_addr",  imem_addr,              32'h0);
    fetch(32'h0, 32'h4015_D513, 0);
    consume('{32'h4015_D513, 32'h0, 32'h4, 7'h13, 3'd5, 1'b1}, 1'b0, 32'h0);
    chk("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);

    // Reset arriving together with imem_ready abandons the fetch.
    wait_req();
    addr_q.push_back(32'h4);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
    tick();
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0; reset = 1'b0;
    check_reset_state("rst_fetch");
    fetch(32'h0, 32'h0050_0093, 1);
    consume('{32'h0050_0093, 32'h0, 32'h4, 7'h13, 3'd0, 1'b0}, 1'b0, 32'h0);

    // PC wrap on the second instance.
    chk("wrap_pc",     w_PC,      32'hFFFF_FFFC);
    chk("wrap_plus4",  w_PCPlus4, 32'h0);
    w_reset = 1'b0;
    begin
      int n = 0;
      while (!w_req && n < 10) begin tick(); n++; end
      if (!w_req) expire("wrap_wait_req");
    end
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_ready = 1'b1; w_rdata = 32'h0050_0093;
    tick();
    w_ready = 1'b0;
    chk("wrap_valid", {31'd0, w_valid}, 32'd1);
    w_advance = 1'b1;
    tick();
    w_advance = 1'b0;
    chk("wrap_req",   {31'd0, w_req}, 32'd1);
    chk("wrap_addr1", w_addr, 32'h0);

    tick();
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("hold_q_empty", hold_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
